// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared definitions for the two-digit seven-segment bus.
//   - SEG_0 .. SEG_F : segment patterns (bit6 = a ... bit0 = g, 1 = lit).
//                      The display driver's encoder uses the same table.
//   - state_t        : capture FSM state encoding.
// -----------------------------------------------------------------------------
package seven_seg_pkg;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } state_t;

endpackage

// File: rtl/seg_decode.sv
// -----------------------------------------------------------------------------
// seg_decode
// Combinational reverse decode of a seven-segment pattern to a hex nibble.
// Ports:
//   seg_i  in  7  segment pattern (bit6 = a ... bit0 = g)
//   nib_o  out 4  decoded nibble (0 when no match)
//   hit_o  out 1  pattern is one of the 16 driver patterns
// -----------------------------------------------------------------------------
module seg_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nib_o,
    output logic       hit_o
);

    always_comb begin
        nib_o = 4'h0;
        hit_o = 1'b1;
        case (seg_i)
            SEG_0:   nib_o = 4'h0;
            SEG_1:   nib_o = 4'h1;
            SEG_2:   nib_o = 4'h2;
            SEG_3:   nib_o = 4'h3;
            SEG_4:   nib_o = 4'h4;
            SEG_5:   nib_o = 4'h5;
            SEG_6:   nib_o = 4'h6;
            SEG_7:   nib_o = 4'h7;
            SEG_8:   nib_o = 4'h8;
            SEG_9:   nib_o = 4'h9;
            SEG_A:   nib_o = 4'hA;
            SEG_B:   nib_o = 4'hB;
            SEG_C:   nib_o = 4'hC;
            SEG_D:   nib_o = 4'hD;
            SEG_E:   nib_o = 4'hE;
            SEG_F:   nib_o = 4'hF;
            default: hit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// -----------------------------------------------------------------------------
// seven_seg_capture
// Receive-side monitor for a two-digit multiplexed seven-segment bus. Waits
// for each digit phase to settle, reverse-decodes it and reassembles the
// 8-bit character (high digit first, then low digit).
//
// state | meaning
// IDLE  | not aligned; waiting for the anode to rise (start of a high phase)
// HI    | high-nibble phase in progress
// LO    | low-nibble phase in progress, high nibble held in hi_nib_q
//
// Ports:
//   clk        in  1  system clock
//   rst        in  1  asynchronous active-high reset
//   anode_in   in  1  digit select (0 = low nibble, 1 = high nibble shown)
//   seg_in     in  7  segment lines, bit6 = a ... bit0 = g, 1 = lit
//   char_out   out 8  last correctly captured character
//   char_valid out 1  one-cycle pulse, char_out updated this cycle
//   seg_err    out 1  one-cycle pulse, phase discarded
//   stalled    out 1  anode has not toggled for TIMEOUT cycles
// -----------------------------------------------------------------------------
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_STABLE  = 4,
    parameter int TIMEOUT     = 64,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       anode_in,
    input  logic [6:0] seg_in,
    output logic [7:0] char_out,
    output logic       char_valid,
    output logic       seg_err,
    output logic       stalled
);

    localparam int STB_W = $clog2(MIN_STABLE + 1);

    logic [SYNC_STAGES-1:0] anode_sync_q;
    logic [6:0]             seg_sync_q [SYNC_STAGES];
    logic                   anode_s;
    logic [6:0]             seg_s;

    logic                   anode_prev_q;
    logic [6:0]             seg_prev_q;
    logic                   toggle;
    logic                   seg_chg;

    logic [STB_W-1:0]       stable_cnt_q, stable_cnt_d;
    logic [6:0]             phase_seg_q;
    logic                   phase_ok_q;
    logic [CNT_W-1:0]       phase_cnt_q, phase_cnt_d;
    logic                   timeout_hit;

    logic [3:0]             dec_nib;
    logic                   dec_hit;
    logic                   phase_good;

    state_t                 state_q;
    logic [3:0]             hi_nib_q;
    logic [7:0]             char_q;
    logic                   valid_q;
    logic                   err_q;
    logic                   stalled_q;

    // Synchronizers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode_sync_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) seg_sync_q[i] <= 7'h00;
        end else begin
            anode_sync_q <= {anode_sync_q[SYNC_STAGES-2:0], anode_in};
            seg_sync_q[0] <= seg_in;
            for (int i = 1; i < SYNC_STAGES; i++) seg_sync_q[i] <= seg_sync_q[i-1];
        end
    end

    assign anode_s = anode_sync_q[SYNC_STAGES-1];
    assign seg_s   = seg_sync_q[SYNC_STAGES-1];
    assign toggle  = (anode_s != anode_prev_q);
    assign seg_chg = (seg_s != seg_prev_q);

    always_comb begin
        stable_cnt_d = stable_cnt_q;
        if (toggle || seg_chg)
            stable_cnt_d = '0;
        else if (stable_cnt_q != STB_W'(MIN_STABLE))
            stable_cnt_d = stable_cnt_q + 1'b1;

        phase_cnt_d = phase_cnt_q;
        if (toggle)
            phase_cnt_d = '0;
        else if (phase_cnt_q != CNT_W'(TIMEOUT))
            phase_cnt_d = phase_cnt_q + 1'b1;
    end

    // Fires once, on the cycle the counter steps onto TIMEOUT; a toggle wins.
    assign timeout_hit = !toggle && (phase_cnt_q == CNT_W'(TIMEOUT - 1));

    // Phase tracking: stability counter and captured pattern
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode_prev_q <= 1'b0;
            seg_prev_q   <= 7'h00;
            stable_cnt_q <= '0;
            phase_cnt_q  <= '0;
            phase_seg_q  <= 7'h00;
            phase_ok_q   <= 1'b0;
        end else begin
            anode_prev_q <= anode_s;
            seg_prev_q   <= seg_s;
            stable_cnt_q <= stable_cnt_d;
            phase_cnt_q  <= phase_cnt_d;
            if (toggle) begin
                phase_ok_q <= 1'b0;
            end else if (!seg_chg && stable_cnt_q == STB_W'(MIN_STABLE)) begin
                // A later stable pattern in the same phase overwrites.
                phase_seg_q <= seg_s;
                phase_ok_q  <= 1'b1;
            end
        end
    end

    seg_decode u_seg_decode (
        .seg_i (phase_seg_q),
        .nib_o (dec_nib),
        .hit_o (dec_hit)
    );

    assign phase_good = phase_ok_q && dec_hit;

    // Capture FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            hi_nib_q  <= 4'h0;
            char_q    <= 8'h00;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (toggle) begin
                stalled_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (anode_s) state_q <= HI;
                    end
                    HI: begin
                        if (phase_good) begin
                            hi_nib_q <= dec_nib;
                            state_q  <= LO;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    LO: begin
                        if (phase_good) begin
                            char_q  <= {hi_nib_q, dec_nib};
                            valid_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        // The toggle that closes a low phase opens a high phase.
                        state_q <= HI;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (timeout_hit) begin
                stalled_q <= 1'b1;
                state_q   <= IDLE;
            end
        end
    end

    assign char_out   = char_q;
    assign char_valid = valid_q;
    assign seg_err    = err_q;
    assign stalled    = stalled_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_capture
// Drives a model of the display driver onto seven_seg_capture and checks the
// reported characters/errors against a scoreboard of expected events.
// -----------------------------------------------------------------------------
module tb_seven_seg_capture;

    localparam int SYNC = 2;
    localparam int MINS = 4;
    localparam int TO   = 64;
    localparam int CW   = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       anode_in;
    logic [6:0] seg_in;
    logic [7:0] char_out;
    logic       char_valid;
    logic       seg_err;
    logic       stalled;

    seven_seg_capture #(
        .SYNC_STAGES (SYNC),
        .MIN_STABLE  (MINS),
        .TIMEOUT     (TO),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .anode_in   (anode_in),
        .seg_in     (seg_in),
        .char_out   (char_out),
        .char_valid (char_valid),
        .seg_err    (seg_err),
        .stalled    (stalled)
    );

    always #5 clk = ~clk;

    // Independent copy of the driver's encoder table (a..g, MSB = a).
    localparam logic [6:0] SEGS [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    typedef struct packed {
        logic       is_err;
        logic [7:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    longint      cyc = 0;
    longint      last_v = -1;
    longint      prev_v = -1;
    logic [7:0]  last_good;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops one expected event per reported event.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b0) begin
            if (char_valid && seg_err) check("both_pulses", 1, 0);
            if (char_valid || seg_err) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_event", {30'd0, char_valid, seg_err}, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("event_is_err", {31'd0, seg_err}, {31'd0, e.is_err});
                    check(seg_err ? "err_hold_char" : "char_out", {24'd0, char_out}, {24'd0, e.val});
                end
                if (char_valid) begin
                    prev_v = last_v;
                    last_v = cyc;
                end
            end
        end
    end

    task automatic push_char(input logic [7:0] c);
        exp_t e;
        e.is_err = 1'b0;
        e.val    = c;
        sb_q.push_back(e);
        last_good = c;
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.val    = last_good;
        sb_q.push_back(e);
    endtask

    task automatic phase(input logic a, input logic [6:0] s, input int len);
        anode_in = a;
        seg_in   = s;
        repeat (len) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input logic [7:0] c);
        push_char(c);
        phase(1'b1, SEGS[c[7:4]], 16);
        phase(1'b0, SEGS[c[3:0]], 16);
    endtask

    // what: 0 = char_valid high, 1 = stalled high, 2 = stalled low.
    // n = edges waited, or -1 when the bound expired.
    task automatic wait_for(input int what, input int limit, output int n);
        bit hit;
        hit = 0;
        n   = 0;
        while (!hit && n < limit) begin
            @(posedge clk);
            #1;
            n++;
            case (what)
                0:       hit = char_valid;
                1:       hit = stalled;
                default: hit = !stalled;
            endcase
        end
        if (!hit) n = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_char_out"}, {24'd0, char_out}, 32'h00);
        check({tag, "_valid"}, {31'd0, char_valid}, 0);
        check({tag, "_err"}, {31'd0, seg_err}, 0);
        check({tag, "_stalled"}, {31'd0, stalled}, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        rst       = 1'b0;
        anode_in  = 1'b0;
        seg_in    = 7'h00;
        last_good = 8'h00;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        phase(1'b0, 7'h00, 4);

        // Nominal cadence, 0xA5; latency and period
        frame(8'hA5);
        push_char(8'hA5);
        anode_in = 1'b1;
        seg_in   = SEGS[4'hA];
        wait_for(0, 20, n);
        check("valid_latency", n, SYNC + 1);
        repeat (16 - n) begin
            @(posedge clk);
            #1;
        end
        phase(1'b0, SEGS[4'h5], 16);
        frame(8'hA5);
        frame(8'hA5);
        check("valid_period", 32'(last_v - prev_v), 32);

        // Character change mid-stream
        frame(8'h3C);
        frame(8'h3C);
        frame(8'hF0);
        frame(8'hF0);
        frame(8'hF0);

        // Invalid low pattern
        frame(8'hA5);
        push_err();
        phase(1'b1, SEGS[4'hA], 16);
        phase(1'b0, 7'b0000001, 16);
        frame(8'hA5);

        // Glitching high phase
        push_err();
        anode_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            seg_in = i[0] ? SEGS[0] : SEGS[8];
            @(posedge clk);
            #1;
        end
        phase(1'b0, SEGS[5], 16);
        frame(8'h12);

        // Stall: anode held high for 200 cycles
        anode_in = 1'b1;
        seg_in   = SEGS[4'hA];
        wait_for(1, 100, n);
        check("stall_rise_edges", n, SYNC + 1 + TO);
        repeat (200 - (n > 0 ? n : 0)) begin
            @(posedge clk);
            #1;
        end
        check("stall_held", {31'd0, stalled}, 1);
        anode_in = 1'b0;
        seg_in   = SEGS[5];
        wait_for(2, 10, n);
        check("stall_fall_edges", n, SYNC + 1);
        repeat (16 - (n > 0 ? n : 0)) begin
            @(posedge clk);
            #1;
        end
        frame(8'hC3);
        frame(8'hC3);

        // Reset during the low phase of 0x5A
        phase(1'b1, SEGS[5], 16);
        phase(1'b0, SEGS[4'hA], 8);
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        last_good = 8'h00;
        phase(1'b0, SEGS[4'hA], 8);
        frame(8'h5A);
        frame(8'h5A);
        phase(1'b1, SEGS[0], 16);
        repeat (8) @(posedge clk);
        #1;
        check("scoreboard_empty", sb_q.size(), 0);
        check("final_char_out", {24'd0, char_out}, 32'h5A);
        check("final_not_stalled", {31'd0, stalled}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
